fir_filter_n: RTL and testbench

Parametrised successor to the 4-tap fir_filter: a TAPS-deep, W-bit sequential FIR with alternating-sign taps, one MAC per cycle. It uses the same data_ready/load_coeff/modwait handshake toward the sample source and the coefficient loader. It adds configurable depth and width, a selectable saturate/wrap output mode, and a programmable sample-block counter.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_mac_unit.sv | 47 ++++
 rtl/fir_filter_n.sv | 170 +++++++++++++++++
 tb/tb_fir_filter_n.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared types and helpers for the parametrised sequential FIR (fir_filter_n).
//   state_t   : controller states, also driven out of the top as a debug port
//   acc_width : signed accumulator width needed so a TAPS-deep sum of
//               (W+1)-bit terms can never overflow internally
// ---------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COEFF = 3'd1,
        SHIFT = 3'd2,
        MAC   = 3'd3,
        STORE = 3'd4
    } state_t;

    // Each truncated product is at most W+1 bits; TAPS of them plus a sign bit.
    function automatic int acc_width(input int taps, input int w);
        return w + 2 + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// ---------------------------------------------------------------------------
// fir_mac_unit
// One multiply-accumulate step per enabled cycle:
//   acc <= acc +/- ((coeff * sample) >> (W-1))
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the accumulator (takes priority over en)
//   en         : accumulate one term this cycle
//   sub        : 1 = subtract the term, 0 = add it
//   coeff      : unsigned Q1.(W-1) coefficient
//   sample     : unsigned sample
//   acc        : signed running sum
// ---------------------------------------------------------------------------
module fir_mac_unit #(
    parameter int W     = 16,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    sub,
    input  logic [W-1:0]            coeff,
    input  logic [W-1:0]            sample,
    output logic signed [ACC_W-1:0] acc
);

    logic [2*W-1:0]          prod;
    logic [W:0]              term;
    logic signed [ACC_W-1:0] term_ext;

    assign prod     = {{W{1'b0}}, coeff} * {{W{1'b0}}, sample};
    // Dropping the low W-1 bits rescales the Q1.(W-1) product back to sample units.
    assign term     = prod[2*W-1:W-1];
    assign term_ext = signed'({{(ACC_W-W-1){1'b0}}, term});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sub ? (acc - term_ext) : (acc + term_ext);
        end
    end

endmodule

// File: rtl/fir_filter_n.sv
// ---------------------------------------------------------------------------
// fir_filter_n
// TAPS-deep, W-bit sequential FIR with alternating-sign taps, one MAC per
// cycle:  y = sum_k (-1)^k * ((c_k * x_k) >> (W-1)),  x_0 = newest sample.
//
// Handshake: data_ready and load_coeff are level requests sampled only in
// IDLE (load_coeff wins when both are high). modwait is a registered busy flag
// that is high in every state other than IDLE; the master must drop its
// request once it sees modwait high, or the request is taken again on return
// to IDLE.
//
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   sample_data      : unsigned input sample
//   fir_coefficient  : Q1.(W-1) coefficient written to the next slot
//   data_ready       : sample request
//   load_coeff       : coefficient write request
//   modwait          : busy
//   fir_out          : last result (held between results)
//   err              : last result was out of range (not sticky)
//   one_k_samples    : one-cycle pulse every SAMPLE_BLOCK results
//   state            : current controller state (debug)
// ---------------------------------------------------------------------------
module fir_filter_n
    import fir_pkg::*;
#(
    parameter int TAPS         = 4,
    parameter int W            = 16,
    parameter int SAT_MODE     = 1,
    parameter int SAMPLE_BLOCK = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sample_data,
    input  logic [W-1:0] fir_coefficient,
    input  logic         data_ready,
    input  logic         load_coeff,
    output logic         modwait,
    output logic [W-1:0] fir_out,
    output logic         err,
    output logic         one_k_samples,
    output state_t       state
);

    localparam int ACC_W = acc_width(TAPS, W);
    localparam int IDX_W = $clog2(TAPS);
    localparam int CNT_W = (SAMPLE_BLOCK > 1) ? $clog2(SAMPLE_BLOCK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_BLOCK - 1);

    state_t                  next_state;
    logic [W-1:0]            coeff [TAPS];
    logic [W-1:0]            hist  [TAPS];
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        tap;
    logic [CNT_W-1:0]        sample_cnt;
    logic signed [ACC_W-1:0] acc;
    logic [W-1:0]            mapped_out;
    logic                    mapped_err;
    logic                    is_neg;
    logic                    is_high;

    // ---------------- controller ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (load_coeff) begin
                    next_state = COEFF;
                end else if (data_ready) begin
                    next_state = SHIFT;
                end
            end
            COEFF:   next_state = IDLE;
            SHIFT:   next_state = MAC;
            MAC:     if (tap == LAST_IDX) next_state = STORE;
            STORE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- MAC datapath ----------------
    fir_mac_unit #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == SHIFT),
        .en     (state == MAC),
        .sub    (tap[0]),
        .coeff  (coeff[tap]),
        .sample (hist[tap]),
        .acc    (acc)
    );

    // ---------------- result mapping ----------------
    always_comb begin
        is_neg     = acc[ACC_W-1];
        is_high    = !acc[ACC_W-1] && (|acc[ACC_W-2:W]);
        mapped_err = is_neg || is_high;
        mapped_out = acc[W-1:0];
        if (SAT_MODE != 0) begin
            if (is_neg) begin
                mapped_out = '0;
            end else if (is_high) begin
                mapped_out = '1;
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                coeff[i] <= '0;
                hist[i]  <= '0;
            end
            ptr           <= '0;
            tap           <= '0;
            sample_cnt    <= '0;
            modwait       <= 1'b0;
            fir_out       <= '0;
            err           <= 1'b0;
            one_k_samples <= 1'b0;
        end else begin
            // Registered from next_state so it falls on the edge that writes fir_out.
            modwait       <= (next_state != IDLE);
            one_k_samples <= 1'b0;
            case (state)
                COEFF: begin
                    coeff[ptr] <= fir_coefficient;
                    ptr        <= (ptr == LAST_IDX) ? '0 : ptr + IDX_W'(1);
                end
                SHIFT: begin
                    hist[0] <= sample_data;
                    for (int i = 1; i < TAPS; i++) begin
                        hist[i] <= hist[i-1];
                    end
                    tap <= '0;
                end
                MAC: begin
                    if (tap != LAST_IDX) begin
                        tap <= tap + IDX_W'(1);
                    end
                end
                STORE: begin
                    fir_out <= mapped_out;
                    err     <= mapped_err;
                    if (sample_cnt == LAST_CNT) begin
                        sample_cnt    <= '0;
                        one_k_samples <= 1'b1;
                    end else begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_n.sv
// ---------------------------------------------------------------------------
// tb_fir_filter_n
// Directed bench for fir_filter_n. Two instances share every input: one
// saturating, one wrapping, both with TAPS=4, W=16, SAMPLE_BLOCK=3.
// Expected values are hand-computed from the filter equation.
// ---------------------------------------------------------------------------
module tb_fir_filter_n;
    import fir_pkg::*;

    localparam int TAPS = 4;
    localparam int W    = 16;
    localparam int SB   = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sample_data;
    logic [W-1:0] fir_coefficient;
    logic         data_ready;
    logic         load_coeff;

    logic         modwait_s, err_s, one_k_s;
    logic [W-1:0] fir_out_s;
    state_t       state_s;
    logic         modwait_w, err_w, one_k_w;
    logic [W-1:0] fir_out_w;
    state_t       state_w;

    int errors = 0;
    int checks = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    fir_filter_n #(.TAPS(TAPS), .W(W), .SAT_MODE(1), .SAMPLE_BLOCK(SB)) dut_sat (
        .clk             (clk),
        .reset           (reset),
        .sample_data     (sample_data),
        .fir_coefficient (fir_coefficient),
        .data_ready      (data_ready),
        .load_coeff      (load_coeff),
        .modwait         (modwait_s),
        .fir_out         (fir_out_s),
        .err             (err_s),
        .one_k_samples   (one_k_s),
        .state           (state_s)
    );

    fir_filter_n #(.TAPS(TAPS), .W(W), .SAT_MODE(0), .SAMPLE_BLOCK(SB)) dut_wrap (
        .clk             (clk),
        .reset           (reset),
        .sample_data     (sample_data),
        .fir_coefficient (fir_coefficient),
        .data_ready      (data_ready),
        .load_coeff      (load_coeff),
        .modwait         (modwait_w),
        .fir_out         (fir_out_w),
        .err             (err_w),
        .one_k_samples   (one_k_w),
        .state           (state_w)
    );

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] v);
        @(negedge clk);
        load_coeff      = 1'b1;
        fir_coefficient = v;
        @(negedge clk);
        load_coeff = 1'b0;
        check("coeff_busy", {31'd0, modwait_s}, 32'd1);
        @(negedge clk);
        check("coeff_idle", {31'd0, modwait_s}, 32'd0);
    endtask

    // Sends one sample and waits for modwait to drop (bounded).
    task automatic send(input logic [W-1:0] v,
                        output logic [W-1:0] fo_s, output logic er_s,
                        output logic [W-1:0] fo_w, output logic er_w,
                        output int busy, output logic pulse, output logic early);
        @(negedge clk);
        data_ready  = 1'b1;
        sample_data = v;
        @(negedge clk);
        data_ready = 1'b0;
        busy  = 0;
        early = 1'b0;
        while (modwait_s && busy < 50) begin
            if (one_k_s) early = 1'b1;
            busy++;
            @(negedge clk);
        end
        fo_s  = fir_out_s;
        er_s  = err_s;
        fo_w  = fir_out_w;
        er_w  = err_w;
        pulse = one_k_s;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] fo_s, fo_w;
        logic         er_s, er_w, pulse, early;
        int           busy;
        logic [W-1:0] smp [4];
        logic [W-1:0] exp_s [4];
        logic [W-1:0] exp_w [4];
        logic         exp_e [4];

        reset           = 1'b1;
        sample_data     = '0;
        fir_coefficient = '0;
        data_ready      = 1'b0;
        load_coeff      = 1'b0;

        // Power-on reset
        #1;
        check("por_fir_out", {16'd0, fir_out_s}, 32'd0);
        check("por_err",     {31'd0, err_s},     32'd0);
        check("por_modwait", {31'd0, modwait_s}, 32'd0);
        check("por_one_k",   {31'd0, one_k_s},   32'd0);
        check("por_state",   {29'd0, state_s},   {29'd0, IDLE});
        @(negedge clk);
        reset = 1'b0;

        // All-zero coefficients
        send(16'd100, fo_s, er_s, fo_w, er_w, busy, pulse, early);
        check("zero_out",  {16'd0, fo_s}, 32'd0);
        check("zero_err",  {31'd0, er_s}, 32'd0);
        check("zero_busy", busy, 32'd6);

        // Mixed-sign coefficients, constant stream of 100
        pulse_reset();
        load(16'h4000); load(16'h8000); load(16'h8000); load(16'h4000);
        smp   = '{16'd100, 16'd100, 16'd100, 16'd100};
        exp_s = '{16'd50, 16'd0, 16'd50, 16'd0};
        exp_w = '{16'd50, 16'hFFCE, 16'd50, 16'd0};
        exp_e = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send(smp[i], fo_s, er_s, fo_w, er_w, busy, pulse, early);
            check($sformatf("mix_sat_out_%0d", i),  {16'd0, fo_s}, {16'd0, exp_s[i]});
            check($sformatf("mix_wrap_out_%0d", i), {16'd0, fo_w}, {16'd0, exp_w[i]});
            check($sformatf("mix_sat_err_%0d", i),  {31'd0, er_s}, {31'd0, exp_e[i]});
            check($sformatf("mix_wrap_err_%0d", i), {31'd0, er_w}, {31'd0, exp_e[i]});
            check($sformatf("mix_busy_%0d", i), busy, 32'd6);
        end

        // Overflow past 2^W-1
        pulse_reset();
        load(16'h8000); load(16'h0000); load(16'h8000); load(16'h0000);
        smp   = '{16'd40000, 16'd0, 16'd40000, 16'd0};
        exp_s = '{16'd40000, 16'd0, 16'd65535, 16'd0};
        exp_w = '{16'd40000, 16'd0, 16'd14464, 16'd0};
        exp_e = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send(smp[i], fo_s, er_s, fo_w, er_w, busy, pulse, early);
            check($sformatf("ovf_sat_out_%0d", i),  {16'd0, fo_s}, {16'd0, exp_s[i]});
            check($sformatf("ovf_wrap_out_%0d", i), {16'd0, fo_w}, {16'd0, exp_w[i]});
            check($sformatf("ovf_err_%0d", i),      {31'd0, er_s}, {31'd0, exp_e[i]});
            if (i == 0) begin
                repeat (3) @(negedge clk);
                check("ovf_hold", {16'd0, fir_out_s}, 32'd40000);
            end
        end

        // Coefficient pointer wrap: fifth write lands in c0
        pulse_reset();
        load(16'h1000); load(16'h2000); load(16'h3000); load(16'h4000); load(16'h8000);
        send(16'd1000, fo_s, er_s, fo_w, er_w, busy, pulse, early);
        check("wrap_c0_out", {16'd0, fo_s}, 32'd1000);
        check("wrap_c0_err", {31'd0, er_s}, 32'd0);
        // c1 = 0x2000 must survive: y = -(0x2000*1000 >> 15) = -250
        send(16'd0, fo_s, er_s, fo_w, er_w, busy, pulse, early);
        check("wrap_c1_sat",  {16'd0, fo_s}, 32'd0);
        check("wrap_c1_wrap", {16'd0, fo_w}, 32'd65286);
        check("wrap_c1_err",  {31'd0, er_s}, 32'd1);

        // load_coeff wins over data_ready in IDLE: busy for only one cycle
        @(negedge clk);
        load_coeff      = 1'b1;
        data_ready      = 1'b1;
        fir_coefficient = 16'h0000;
        sample_data     = 16'd7;
        @(negedge clk);
        load_coeff = 1'b0;
        data_ready = 1'b0;
        check("prio_busy", {31'd0, modwait_s}, 32'd1);
        @(negedge clk);
        check("prio_idle", {31'd0, modwait_s}, 32'd0);

        // Sample block counter
        pulse_reset();
        load(16'h8000);
        for (int i = 1; i <= 6; i++) begin
            send(W'(11 * i), fo_s, er_s, fo_w, er_w, busy, pulse, early);
            check($sformatf("blk_out_%0d", i),   {16'd0, fo_s}, 11 * i);
            check($sformatf("blk_pulse_%0d", i), {31'd0, pulse}, (i % 3 == 0) ? 32'd1 : 32'd0);
            check($sformatf("blk_early_%0d", i), {31'd0, early}, 32'd0);
            @(negedge clk);
            check($sformatf("blk_width_%0d", i), {31'd0, one_k_s}, 32'd0);
        end

        // Seventh sample aborted by reset during MAC, between clock edges
        @(negedge clk);
        data_ready  = 1'b1;
        sample_data = 16'd77;
        @(negedge clk);
        data_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_modwait", {31'd0, modwait_s}, 32'd0);
        check("abort_fir_out", {16'd0, fir_out_s}, 32'd0);
        check("abort_err",     {31'd0, err_s},     32'd0);
        check("abort_state",   {29'd0, state_s},   {29'd0, IDLE});
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            send(16'd5, fo_s, er_s, fo_w, er_w, busy, pulse, early);
            check($sformatf("post_pulse_%0d", i), {31'd0, pulse}, (i == 3) ? 32'd1 : 32'd0);
            check($sformatf("post_out_%0d", i),   {16'd0, fo_s}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
